data_ram_pipe: RTL and testbench
================================

DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; legal values are 32 and 64.
REQ-003 SHALL have parameter DEPTH_WORDS, default 64, word count; must be a power of two, at least 2.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, ports as below.
REQ-005 SHALL have port clk_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port req_valid_i, input, 1 bit: request present.
REQ-008 SHALL have port req_ready_o, output, 1 bit: request accepted this cycle when both valid and ready are high.
REQ-009 SHALL have port req_addr_i, input, ADDR_WIDTH bits: byte address.
REQ-010 SHALL have port req_we_i, input, 1 bit: 1 for write, 0 for read.
REQ-011 SHALL have port req_be_i, input, DATA_WIDTH/8 bits: byte enables for writes.
REQ-012 SHALL have port req_wdata_i, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port rsp_valid_o, output, 1 bit: response present.
REQ-014 SHALL have port rsp_ready_i, input, 1 bit: consumer accepts the response.
REQ-015 SHALL have port rsp_rdata_o, output, DATA_WIDTH bits: read data.
REQ-016 SHALL have port rsp_err_o, output, 1 bit: address out of range.
REQ-017 SHALL have port init_done_o, output, 1 bit: memory clear complete.

Function
REQ-018 SHALL implement an FSM with two states, INIT and RUN; reset enters INIT with the clear counter at 0.
REQ-019 In INIT, SHALL write all-zero to word[counter] each cycle and increment the counter; after word DEPTH_WORDS-1 it SHALL enter RUN, so INIT lasts exactly DEPTH_WORDS cycles.
REQ-020 SHALL drive init_done_o to 1 only in RUN.
REQ-021 SHALL drive req_ready_o = init_done_o && (!rsp_valid_o || rsp_ready_i), giving one request per cycle throughput.
REQ-022 SHALL form the word index as req_addr_i[OFF +: log2(DEPTH_WORDS)], where OFF = log2(DATA_WIDTH/8); address bits below OFF SHALL be ignored.
REQ-023 SHALL flag a request out-of-range when any address bit above the index field is nonzero; such a request SHALL modify no memory and SHALL respond with rsp_err_o=1 and rsp_rdata_o=0.
REQ-024 On an accepted in-range write, SHALL update exactly the bytes whose req_be_i bit is 1, at the acceptance edge.
REQ-025 A write with req_be_i all zero SHALL change no memory and SHALL respond normally.
REQ-026 On an accepted read, SHALL present the word's contents one cycle later on rsp_rdata_o, with rsp_err_o=0.
REQ-027 Every accepted request SHALL produce exactly one response, with rsp_valid_o high the cycle after acceptance.
REQ-028 A write response SHALL carry rsp_rdata_o=0.
REQ-029 While rsp_valid_o && !rsp_ready_i, rsp_rdata_o and rsp_err_o SHALL hold stable and no new request SHALL be accepted.
REQ-030 When the response handshake and a new acceptance occur in the same cycle, SHALL replace the response with the new one; otherwise SHALL clear rsp_valid_o on the handshake.
REQ-031 A read in the cycle after a write to the same word SHALL return the newly written data.
REQ-032 The index field SHALL not wrap; the top word is DEPTH_WORDS-1, and higher addresses are out-of-range per REQ-023.

Reset
REQ-033 Asserting rst_i SHALL asynchronously force req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, init_done_o=0, FSM=INIT, and counter=0.
REQ-034 Reset during RUN SHALL discard any pending response; after release, SHALL re-clear the whole memory per REQ-019.
REQ-035 SHALL not reset the storage array directly; clearing happens only through INIT.

Structure
REQ-036 SHALL define the state enum (INIT, RUN) and a response struct {rdata, err} in the shared package data_ram_pkg.
REQ-037 SHALL place storage in a sub-module data_ram_mem: single port, byte-write enables, synchronous read, no reset.
REQ-038 SHALL derive OFF and the index width with $clog2 inside the module; no hard-coded 31:2 slicing.

Verification
REQ-039 Reset, then DEPTH_WORDS=64 -> init_done_o rises exactly 64 cycles after release; a read of every word returns 0.
REQ-040 Write 0xDEADBEEF to 0x10 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read 0x10 -> 0xDEADBEAA, err=0.
REQ-041 Read 0x100 with DEPTH_WORDS=64 and DATA_WIDTH=32 -> rsp_err_o=1, rdata=0; a following read of 0x0 shows it unchanged.
REQ-042 Hold rsp_ready_i=0 for 3 cycles after a read -> req_ready_o=0 and the response stays stable; back-to-back requests at rsp_ready_i=1 -> one response per cycle, in order.
REQ-043 Assert rst_i while a response is pending -> rsp_valid_o=0 immediately; after release, INIT repeats and earlier data reads back 0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// ============================================================================
// Module      : data_ram_pkg
// Description : Shared types for the pipelined data RAM (FSM states, response).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_ram_pkg;

    localparam int MAX_DATA_WIDTH = 64;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/data_ram_pipe_if.sv
// ============================================================================
// Module      : data_ram_pipe_if
// Description : Request/response bus of the pipelined data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_ram_pipe_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic                    req_we_i;
    logic [DATA_WIDTH/8-1:0] req_be_i;
    logic [DATA_WIDTH-1:0]   req_wdata_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [DATA_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;
    logic                    init_done_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o
    );
endinterface

`default_nettype wire

// File: rtl/data_ram_mem.sv
// ============================================================================
// Module      : data_ram_mem
// Description : Single-port RAM, byte write enables, registered read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
    input  wire logic                    clk,
    input  wire logic                    i_en,
    input  wire logic                    i_we,
    input  wire logic [DATA_WIDTH/8-1:0] i_be,
    input  wire logic [IDX_WIDTH-1:0]    i_addr,
    input  wire logic [DATA_WIDTH-1:0]   i_wdata,
    output      logic [DATA_WIDTH-1:0]   o_rdata
);
    localparam int c_BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read data only reloads on a read, so it holds while a response is stalled.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < c_BE_W; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/data_ram_pipe.sv
// ============================================================================
// Module      : data_ram_pipe
// Description : Valid/ready data RAM with power-up clear and one-cycle response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_pipe
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64
) (
    input wire logic         clk_i,
    input wire logic         rst_i,
    data_ram_pipe_if.slave   bus
);
    localparam int c_OFF   = $clog2(DATA_WIDTH / 8);
    localparam int c_IDX_W = $clog2(DEPTH_WORDS);
    localparam int c_BE_W  = DATA_WIDTH / 8;

    state_e              r_state;
    state_e              w_state_next;
    logic [c_IDX_W-1:0]  r_cnt;
    logic                w_init_we;
    logic                w_init_done;
    logic                w_ready;
    logic                w_accept;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_oob;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic                r_rsp_rd;
    logic                w_mem_en;
    logic                w_mem_we;
    logic [c_BE_W-1:0]   w_mem_be;
    logic [c_IDX_W-1:0]  w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    rsp_t                w_rsp;
    logic                w_unused_rdata;

    assign w_idx = bus.req_addr_i[c_OFF +: c_IDX_W];
    assign w_oob = (bus.req_addr_i >> (c_OFF + c_IDX_W)) != '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_init_we) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_init_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we = 1'b1;
                if (r_cnt == c_IDX_W'(DEPTH_WORDS - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_init_done = (r_state == ST_RUN);
    assign w_ready     = w_init_done && (!r_rsp_valid || bus.rsp_ready_i);
    assign w_accept    = bus.req_valid_i && w_ready;

    // A new acceptance overwrites the response slot; a bare handshake empties it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_oob;
            r_rsp_rd    <= !bus.req_we_i && !w_oob;
        end else if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign w_mem_en    = w_init_we || (w_accept && !w_oob);
    assign w_mem_we    = w_init_we || bus.req_we_i;
    assign w_mem_be    = w_init_we ? {c_BE_W{1'b1}} : bus.req_be_i;
    assign w_mem_addr  = w_init_we ? r_cnt : w_idx;
    assign w_mem_wdata = w_init_we ? '0 : bus.req_wdata_i;

    data_ram_mem #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_WIDTH   (c_IDX_W)
    ) u_mem (
        .clk     (clk_i),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_be    (w_mem_be),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_rsp       = '0;
        w_rsp.err   = r_rsp_err;
        if (r_rsp_rd) begin
            w_rsp.rdata[DATA_WIDTH-1:0] = w_mem_rdata;
        end
    end

    assign w_unused_rdata  = &{1'b0, w_rsp.rdata};

    assign bus.req_ready_o = w_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = w_rsp.rdata[DATA_WIDTH-1:0];
    assign bus.rsp_err_o   = w_rsp.err;
    assign bus.init_done_o = w_init_done;

endmodule

`default_nettype wire

// File: tb/tb_data_ram_pipe.sv
// ============================================================================
// Module      : tb_data_ram_pipe
// Description : Self-checking bench for data_ram_pipe (vectors + random model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_pipe;
    import data_ram_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    data_ram_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_ram_pipe #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] model_mem [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request and return its response; leaves rsp_ready_i untouched.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int n;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_be_i    = be;
        bus.req_wdata_i = wdata;
        n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("req_ready before accept", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        chk("rsp_valid after accept", 64'(bus.rsp_valid_o), 64'd1);
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        m_valid;
        logic [31:0] m_rdata;
        logic        m_err;
        int          n;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 4'h1, 32'h0000_00AA, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEAA, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0010, 4'h0, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,         32'hDEAD_BEAA, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_00FC, 4'hC, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_00FF, 4'h0, 32'h0,         32'h1234_0000, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0044, 4'h6, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0044, 4'h0, 32'h0,         32'h00BB_CC00, 1'b0};

        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_be_i    = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b1;

        // Reset state and clear duration
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset init_done", 64'(bus.init_done_o), 64'd0);
        chk("reset req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("reset rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        rst_i = 1'b0;
        repeat (DEPTH - 1) @(posedge clk_i);
        #1;
        chk("init_done before last clear", 64'(bus.init_done_o), 64'd0);
        @(posedge clk_i); #1;
        chk("init_done after clear", 64'(bus.init_done_o), 64'd1);

        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b0, 32'(i * 4), 4'h0, 32'h0, rd, er);
            chk($sformatf("cleared word %0d", i), {31'd0, er, rd}, 64'd0);
        end

        // Vector table
        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er);
            chk($sformatf("vec %0d rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            chk($sformatf("vec %0d err", i), 64'(er), 64'(vecs[i].exp_err));
        end

        // Back-to-back reads: one response per cycle, in order
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'h20 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i), rd, er);
        end
        for (int i = 0; i < 4; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_we_i    = 1'b0;
            bus.req_addr_i  = 32'h20 + 32'(i * 4);
            @(posedge clk_i); #1;
            chk($sformatf("b2b rsp_valid %0d", i), 64'(bus.rsp_valid_o), 64'd1);
            chk($sformatf("b2b rdata %0d", i), 64'(bus.rsp_rdata_o), 64'hA000_0000 + 64'(i));
        end
        bus.req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("b2b rsp cleared", 64'(bus.rsp_valid_o), 64'd0);

        // Stalled response holds and blocks acceptance
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 32'h10;
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_be_i    = 4'hF;
        bus.req_wdata_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall req_ready %0d", k), 64'(bus.req_ready_o), 64'd0);
            chk($sformatf("stall rdata %0d", k), {31'd0, bus.rsp_err_o, bus.rsp_rdata_o},
                64'hDEAD_BEAA);
            chk($sformatf("stall rsp_valid %0d", k), 64'(bus.rsp_valid_o), 64'd1);
            @(posedge clk_i); #1;
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        chk("post-stall write rsp", {31'd0, bus.rsp_valid_o, bus.rsp_rdata_o}, 64'h1_0000_0000);
        do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, er);
        chk("post-stall readback", 64'(rd), 64'hFFFF_FFFF);

        // Reset with a pending response
        @(posedge clk_i); #1;
        bus.rsp_ready_i = 1'b0;
        do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, er);
        #2 rst_i = 1'b1;
        #1;
        chk("async rst rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("async rst outputs",
            {bus.req_ready_o, bus.init_done_o, bus.rsp_err_o, bus.rsp_rdata_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        n = 0;
        while (!bus.init_done_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("re-init cycles", 64'(n), 64'd64);
        do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, er);
        chk("re-cleared 0x10", 64'(rd), 64'd0);
        do_req(1'b0, 32'h20, 4'h0, 32'h0, rd, er);
        chk("re-cleared 0x20", 64'(rd), 64'd0);

        // Randomized traffic against a transaction-level model
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        m_valid = 1'b1;
        m_rdata = 32'd0;
        m_err   = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic        exp_ready;
            logic [31:0] a;
            logic [31:0] w;
            bus.req_valid_i = ($urandom_range(0, 3) != 0);
            bus.req_we_i    = $urandom_range(0, 1) == 1;
            bus.req_addr_i  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 300);
            bus.req_be_i    = 4'($urandom);
            bus.req_wdata_i = $urandom;
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            exp_ready = !m_valid || bus.rsp_ready_i;
            chk("rand req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
            chk("rand rsp_valid", 64'(bus.rsp_valid_o), 64'(m_valid));
            if (m_valid) begin
                chk("rand rsp", {31'd0, bus.rsp_err_o, bus.rsp_rdata_o}, {31'd0, m_err, m_rdata});
            end
            if (bus.req_valid_i && exp_ready) begin
                a = bus.req_addr_i;
                m_valid = 1'b1;
                m_rdata = 32'd0;
                m_err   = 1'b0;
                if (a >= 32'(DEPTH * 4)) begin
                    m_err = 1'b1;
                end else if (bus.req_we_i) begin
                    w = model_mem[a / 4];
                    for (int b = 0; b < 4; b++) begin
                        if (bus.req_be_i[b]) w[b*8 +: 8] = bus.req_wdata_i[b*8 +: 8];
                    end
                    model_mem[a / 4] = w;
                end else begin
                    m_rdata = model_mem[a / 4];
                end
            end else if (bus.rsp_ready_i) begin
                m_valid = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
